// File: rtl/alu_writeback.sv
// ALU result writeback: routes a result to the register file, the PC or memory.
// Optional status flag register is built when WB_FLAGS_EN is defined.
module alu_writeback #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_valid,
    output logic             o_wb_ready,
    input  logic [2:0]       i_wb_sel,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic [3:0]       i_alu_flags,
    input  logic             i_flag_we,
    input  logic [RA_W-1:0]  i_rd_addr,
    input  logic [WIDTH-1:0] i_mar,
    output logic             o_reg_we,
    output logic [RA_W-1:0]  o_reg_waddr,
    output logic [WIDTH-1:0] o_reg_wdata,
    output logic             o_pc_we,
    output logic [WIDTH-1:0] o_pc_wdata,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic             i_mem_ack,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic [3:0]       o_sr_flags,
    output logic             o_sel_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_MEM    = 2'd2;
    localparam logic [1:0] S_RDWB   = 2'd3;

    localparam logic [2:0] SEL_REG  = 3'b001;
    localparam logic [2:0] SEL_PC   = 3'b010;
    localparam logic [2:0] SEL_MWR  = 3'b011;
    localparam logic [2:0] SEL_MRD  = 3'b100;

    logic [1:0]       r_state;
    logic [2:0]       r_sel;
    logic [WIDTH-1:0] r_alu;
    logic [WIDTH-1:0] r_mar;
    logic [WIDTH-1:0] r_rdata;
    logic [RA_W-1:0]  r_rd;

    logic w_accept;
    logic w_commit;
    logic w_is_mem;
    logic w_is_rsv;
    logic w_done;

    assign w_accept = i_wb_valid && (r_state == S_IDLE);
    assign w_commit = (r_state == S_COMMIT);
    assign w_is_mem = (r_sel == SEL_MWR) || (r_sel == SEL_MRD);
    assign w_is_rsv = (r_sel > SEL_MRD);
    assign w_done   = o_mem_req && i_mem_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_alu   <= '0;
            r_mar   <= '0;
            r_rdata <= '0;
            r_rd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= i_wb_sel;
                        r_alu   <= i_alu_out;
                        r_mar   <= i_mar;
                        r_rd    <= i_rd_addr;
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT, S_MEM: begin
                    if (!w_is_mem) begin
                        r_state <= S_IDLE;
                    end else if (w_done) begin
                        if (r_sel == SEL_MRD) begin
                            r_rdata <= i_mem_rdata;
                            r_state <= S_RDWB;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_state <= S_MEM;
                    end
                end
                S_RDWB:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_wb_ready  = (r_state == S_IDLE);
    assign o_reg_we    = (w_commit && r_sel == SEL_REG) || (r_state == S_RDWB);
    assign o_reg_waddr = r_rd;
    assign o_reg_wdata = (r_state == S_RDWB) ? r_rdata : r_alu;
    assign o_pc_we     = w_commit && (r_sel == SEL_PC);
    assign o_pc_wdata  = r_alu;
    assign o_sel_err   = w_commit && w_is_rsv;

    // Memory outputs come straight from captured state so they hold through MEM.
    assign o_mem_req   = w_is_mem && (w_commit || r_state == S_MEM);
    assign o_mem_we    = o_mem_req && (r_sel == SEL_MWR);
    assign o_mem_addr  = (r_sel == SEL_MWR) ? r_mar : r_alu;
    assign o_mem_wdata = r_alu;

`ifdef WB_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] r_sr;
    logic       r_fwe;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= '0;
            r_fwe   <= 1'b0;
            r_sr    <= '0;
        end else begin
            if (w_accept) begin
                r_flags <= i_alu_flags;
                r_fwe   <= i_flag_we;
            end
            if (w_commit && r_fwe) begin
                r_sr <= r_flags;
            end
        end
    end

    assign o_sr_flags = r_sr;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{i_alu_flags, i_flag_we};
    assign o_sr_flags     = 4'b0000;
`endif

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Result-side counterpart of the ALU input bus mux. Accepts one ALU result per transaction and routes it to the register file write port, the PC load port or the memory bus; it also latches the ALU status flags. Memory transactions use a req/ack handshake with a multi-cycle wait. The block sits between the ALU output and the register file / PC / memory interface, under control-unit handshake.

## Interface
- WIDTH, 16, datapath width
- RA_W, 3, register index width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  control unit offers a result
- wb_ready  out  1  block can accept (high only in IDLE)
- wb_sel  in  3  destination: 000 none, 001 reg, 010 pc, 011 mem write, 100 mem read→reg, 101–111 reserved
- alu_out  in  WIDTH  ALU result (data, or address for 100)
- alu_flags  in  4  {S,V,Z,C} from ALU
- flag_we  in  1  update status flags with this transaction
- rd_addr  in  RA_W  destination register
- mar  in  WIDTH  memory address for 011
- reg_we / reg_waddr / reg_wdata  out  1 / RA_W / WIDTH  register write port
- pc_we / pc_wdata  out  1 / WIDTH  PC load port
- mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / WIDTH / WIDTH  memory request
- mem_ack  in  1  memory completes request
- mem_rdata  in  WIDTH  read data, valid with mem_ack
- sr_flags  out  4  status flags register
- sel_err  out  1  one-cycle pulse on reserved wb_sel

## Operation
- States: IDLE, COMMIT, MEM, RDWB.
- Accept when wb_valid && wb_ready; capture wb_sel, alu_out, alu_flags, flag_we, rd_addr, mar.
- IDLE→COMMIT on accept.
- COMMIT: sel 001 → reg_we=1, reg_waddr=rd_addr, reg_wdata=alu_out; sel 010 → pc_we=1, pc_wdata=alu_out; sel 000 → no write; reserved → no write, sel_err=1. Next state IDLE, except sel 011/100 → MEM.
- COMMIT with sel 011/100: mem_req asserted from this cycle; mem_addr = mar (011) or alu_out (100); mem_we = 1 for 011 only; mem_wdata = alu_out.
- MEM: hold mem_req and all mem_* outputs stable until mem_ack. On ack: 011 → IDLE; 100 → capture mem_rdata, go to RDWB.
- RDWB: reg_we=1, reg_waddr=rd_addr, reg_wdata=captured read data; →IDLE.
- Flags: sr_flags <= captured alu_flags in COMMIT when captured flag_we=1, for any wb_sel including reserved.
- mem_ack outside COMMIT/MEM is ignored. Inputs other than mem_ack/mem_rdata are don't-care outside the accept cycle.

## Timing
- Reset (asynchronous): state IDLE, wb_ready=1, all *_we, mem_req, mem_we, sel_err=0; data/address outputs 0; sr_flags=0.
- Reset mid-MEM: mem_req drops immediately; no register write.
- reg/pc write: one cycle after accept. Throughput: one non-memory transaction per 2 cycles.
- Memory write: mem_req is first high 1 cycle after accept. mem_ack in that same cycle completes the request; mem_req is low the next cycle. wb_ready returns 1 the cycle after ack.
- Memory read: reg_we is high the cycle after ack. Minimum 3 cycles from accept to IDLE.
- reg_we, pc_we and sel_err are single-cycle pulses, mutually exclusive in a cycle.

## Configuration
- WB_FLAGS_EN defined: status flag register and flag_we path present as above.
- WB_FLAGS_EN undefined: no flag register; sr_flags tied to 0; flag_we and alu_flags ignored. All other behaviour is identical.

## Test plan
- Reset, then sel=001, rd_addr=5, alu_out=16'h1234 → next cycle reg_we=1, reg_waddr=5, reg_wdata=16'h1234; wb_ready low for exactly 1 cycle.
- sel=010, alu_out=16'h00F0 → pc_we=1, pc_wdata=16'h00F0 one cycle after accept; reg_we stays 0.
- sel=011, mar=16'h0040, alu_out=16'hBEEF, mem_ack after 3 cycles → mem_req/mem_we high and stable for 4 cycles, mem_addr=16'h0040, mem_wdata=16'hBEEF; wb_ready=1 the cycle after ack.
- sel=100, alu_out=16'h0080, ack in first req cycle with mem_rdata=16'hCAFE → mem_addr=16'h0080, mem_we=0; next cycle reg_we=1 with reg_wdata=16'hCAFE.
- sel=110, flag_we=1, alu_flags=4'b0101 → sel_err pulse, no writes, sr_flags=4'b0101 (0 when WB_FLAGS_EN undefined).
- Assert rst while in MEM → mem_req low immediately, state IDLE, no reg_we after release.
